// File: rtl/sigsource_pkg.sv
// rtl/sigsource_pkg.sv - shared FSM state type and default sizing for the signal-source stage
package sigsource_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } seq_state_e;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_TRATE = 30;
  localparam int unsigned DEF_ACCUM = 64;

endpackage

// File: rtl/sigfifo2.sv
// rtl/sigfifo2.sv - two-entry sample FIFO with full/empty flags
module sigfifo2 #(
  parameter int unsigned DW = 64
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [DW-1:0] mem_q [2];
  logic          wptr_q;
  logic          rptr_q;
  logic [1:0]    count_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign rdata_o = mem_q[rptr_q];

  // A push while full is only honoured when the head leaves on the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= ~wptr_q;
      end
      if (do_pop) begin
        rptr_q <= ~rptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sigsequencer.sv
// rtl/sigsequencer.sv - replays each buffered IQ sample TRATE times with block framing
module sigsequencer
  import sigsource_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  parameter  int unsigned TRATE = DEF_TRATE,
  parameter  int unsigned ACCUM = DEF_ACCUM,
  localparam int unsigned TBITS = $clog2(TRATE),
  localparam int unsigned CBITS = $clog2(ACCUM)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en_i,
  input  logic             sig_valid_i,
  output logic             sig_ready_o,
  input  logic [WIDTH-1:0] sig_idata_i,
  input  logic [WIDTH-1:0] sig_qdata_i,
  output logic             valid_o,
  output logic             first_o,
  output logic             next_o,
  output logic             last_o,
  output logic [TBITS-1:0] taddr_o,
  output logic [WIDTH-1:0] idata_o,
  output logic [WIDTH-1:0] qdata_o,
  output logic             underrun_o
);

  localparam logic [TBITS-1:0] TLAST = TBITS'(TRATE - 1);
  localparam logic [CBITS-1:0] CLAST = CBITS'(ACCUM - 1);

  seq_state_e         state_q, state_d;
  logic [TBITS-1:0]   taddr_q, taddr_d;
  logic [CBITS-1:0]   scount_q, scount_d;
  logic               valid_q, valid_d;
  logic               first_q, first_d;
  logic               next_q, next_d;
  logic               last_q, last_d;
  logic               underrun_q;
  logic               rdy_q;
  logic [WIDTH-1:0]   idata_q, qdata_q;
  logic               pop;
  logic               push;
  logic               fifo_full;
  logic               fifo_empty;
  logic [2*WIDTH-1:0] fifo_rdata;

  // rdy_q keeps the input closed until the first edge after reset release.
  assign sig_ready_o = rdy_q && !fifo_full;
  assign push        = sig_valid_i && sig_ready_o;

  sigfifo2 #(
    .DW (2 * WIDTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .wdata_i ({sig_idata_i, sig_qdata_i}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    taddr_d  = taddr_q;
    scount_d = scount_q;
    pop      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        taddr_d  = '0;
        scount_d = '0;
        if (en_i && !fifo_empty) begin
          state_d = ST_RUN;
          pop     = 1'b1;
        end
      end
      ST_RUN: begin
        if (taddr_q != TLAST) begin
          taddr_d = taddr_q + TBITS'(1);
        end else begin
          taddr_d = '0;
          if (scount_q == CLAST) begin
            // Block boundary: the only place en_i is honoured.
            scount_d = '0;
            if (en_i && !fifo_empty) begin
              pop = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            scount_d = scount_q + CBITS'(1);
            if (!fifo_empty) begin
              pop = 1'b1;
            end else begin
              state_d = ST_STALL;
            end
          end
        end
      end
      ST_STALL: begin
        if (!fifo_empty) begin
          state_d = ST_RUN;
          pop     = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Framing is derived from the next counters so every strobe is registered.
    valid_d = (state_d == ST_RUN);
    first_d = valid_d && (taddr_d == '0) && (scount_d == '0);
    next_d  = valid_d && (taddr_d == TLAST);
    last_d  = next_d && (scount_d == CLAST);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      taddr_q    <= '0;
      scount_q   <= '0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      next_q     <= 1'b0;
      last_q     <= 1'b0;
      underrun_q <= 1'b0;
      rdy_q      <= 1'b0;
      idata_q    <= '0;
      qdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      taddr_q    <= taddr_d;
      scount_q   <= scount_d;
      valid_q    <= valid_d;
      first_q    <= first_d;
      next_q     <= next_d;
      last_q     <= last_d;
      underrun_q <= underrun_q || (state_d == ST_STALL);
      rdy_q      <= 1'b1;
      if (pop) begin
        {idata_q, qdata_q} <= fifo_rdata;
      end
    end
  end

  assign valid_o    = valid_q;
  assign first_o    = first_q;
  assign next_o     = next_q;
  assign last_o     = last_q;
  assign taddr_o    = taddr_q;
  assign idata_o    = idata_q;
  assign qdata_o    = qdata_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_sigsequencer.sv
// tb/tb_sigsequencer.sv - directed and scoreboarded bench for sigsequencer
module tb_sigsequencer;

  localparam int W  = 8;
  localparam int TR = 4;
  localparam int AC = 2;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         en_i = 1'b0;
  logic         sig_valid_i = 1'b0;
  logic [W-1:0] sig_idata_i = '0;
  logic [W-1:0] sig_qdata_i = '0;
  logic         sig_ready_o;
  logic         valid_o, first_o, next_o, last_o, underrun_o;
  logic [1:0]   taddr_o;
  logic [W-1:0] idata_o, qdata_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] got, exp;

  sigsequencer #(.WIDTH(W), .TRATE(TR), .ACCUM(AC)) dut (
    .clock       (clock),
    .reset       (reset),
    .en_i        (en_i),
    .sig_valid_i (sig_valid_i),
    .sig_ready_o (sig_ready_o),
    .sig_idata_i (sig_idata_i),
    .sig_qdata_i (sig_qdata_i),
    .valid_o     (valid_o),
    .first_o     (first_o),
    .next_o      (next_o),
    .last_o      (last_o),
    .taddr_o     (taddr_o),
    .idata_o     (idata_o),
    .qdata_o     (qdata_o),
    .underrun_o  (underrun_o)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en_i = 1'b0; sig_valid_i = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic drive(input logic [W-1:0] d);
    sig_idata_i = d;
    sig_qdata_i = ~d;
  endtask

  task automatic test_reset();
    reset = 1'b1; en_i = 1'b0; sig_valid_i = 1'b0;
    tick();
    got = 64'({valid_o, first_o, next_o, last_o, underrun_o, taddr_o, idata_o, qdata_o, sig_ready_o});
    exp = 64'd0;
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_outputs: got %h expected %h", got, exp); end
    #2; reset = 1'b0; #1;
    n_checks++;
    if (sig_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready_pre_edge: got %b expected 0", sig_ready_o); end
    tick();
    got = 64'({sig_ready_o, valid_o});
    exp = 64'({1'b1, 1'b0});
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_ready_post_edge: got %h expected %h", got, exp); end
  endtask

  task automatic test_single();
    do_reset();
    en_i = 1'b1; sig_valid_i = 1'b1; drive(8'hA1);
    tick();
    sig_valid_i = 1'b0;
    n_checks++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL single_latency: got valid %b expected 0", valid_o); end
    for (int c = 0; c < TR; c++) begin
      tick();
      got = 64'({valid_o, first_o, next_o, last_o, underrun_o, taddr_o, idata_o, qdata_o});
      exp = 64'({1'b1, c == 0, c == TR - 1, 1'b0, 1'b0, 2'(c), 8'hA1, 8'h5E});
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL single_frame c=%0d: got %h expected %h", c, got, exp); end
    end
    tick();
    got = 64'({valid_o, underrun_o, taddr_o, next_o});
    exp = 64'({1'b0, 1'b1, 2'd0, 1'b0});
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL single_stall: got %h expected %h", got, exp); end
  endtask

  task automatic test_two();
    do_reset();
    sig_valid_i = 1'b1; drive(8'h11);
    tick();
    drive(8'h22);
    tick();
    sig_valid_i = 1'b0;
    got = 64'({sig_ready_o, valid_o});
    exp = 64'd0;
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL two_full: got %h expected %h", got, exp); end
    en_i = 1'b1;
    for (int c = 0; c < 2 * TR; c++) begin
      tick();
      got = 64'({valid_o, first_o, next_o, last_o, taddr_o, idata_o});
      exp = 64'({1'b1, c == 0, (c % TR) == TR - 1, c == 2 * TR - 1, 2'(c % TR), (c < TR) ? 8'h11 : 8'h22});
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL two_frame c=%0d: got %h expected %h", c, got, exp); end
    end
    tick();
    got = 64'({valid_o, underrun_o, last_o, sig_ready_o});
    exp = 64'({1'b0, 1'b0, 1'b0, 1'b1});
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL two_idle: got %h expected %h", got, exp); end
  endtask

  task automatic test_stream();
    int  cnt = 0;
    int  pushed = 0;
    bit  do_push, do_pop;
    do_reset();
    en_i = 1'b1; sig_valid_i = 1'b1;
    for (int e = 0; e < 26; e++) begin
      drive(8'(pushed + 1));
      do_push = (cnt < 2);
      do_pop  = (e >= 1) && (((e - 1) % TR) == 0);
      tick();
      cnt = cnt + int'(do_push) - int'(do_pop);
      if (do_push) pushed++;
      n_checks++;
      if (sig_ready_o !== (cnt < 2)) begin n_fail++; $display("FAIL stream_ready e=%0d: got %b expected %b", e, sig_ready_o, cnt < 2); end
      if (e >= 1) begin
        got = 64'({valid_o, first_o, last_o, taddr_o, idata_o, qdata_o});
        exp = 64'({1'b1, ((e - 1) % (TR * AC)) == 0, ((e - 1) % (TR * AC)) == TR * AC - 1,
                   2'((e - 1) % TR), 8'((e - 1) / TR + 1), ~8'((e - 1) / TR + 1)});
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL stream_frame e=%0d: got %h expected %h", e, got, exp); end
      end
    end
    sig_valid_i = 1'b0;
  endtask

  task automatic test_en_drop();
    do_reset();
    en_i = 1'b1; sig_valid_i = 1'b1; drive(8'h31);
    tick();
    drive(8'h32);
    tick();
    drive(8'h33);
    tick();
    sig_valid_i = 1'b0; en_i = 1'b0;
    for (int c = 2; c < 2 * TR; c++) begin
      tick();
      got = 64'({valid_o, last_o, taddr_o, idata_o});
      exp = 64'({1'b1, c == 2 * TR - 1, 2'(c % TR), (c < TR) ? 8'h31 : 8'h32});
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL en_drop_frame c=%0d: got %h expected %h", c, got, exp); end
    end
    tick();
    tick();
    got = 64'({valid_o, sig_ready_o});
    exp = 64'({1'b0, 1'b1});
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL en_drop_idle: got %h expected %h", got, exp); end
    en_i = 1'b1;
    tick();
    got = 64'({valid_o, first_o, taddr_o, idata_o});
    exp = 64'({1'b1, 1'b1, 2'd0, 8'h33});
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL en_drop_resume: got %h expected %h", got, exp); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en_i = 1'b1; sig_valid_i = 1'b1; drive(8'h41);
    tick();
    sig_valid_i = 1'b0;
    tick(); tick(); tick();
    got = 64'({valid_o, taddr_o});
    exp = 64'({1'b1, 2'd2});
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL rst_mid_pre: got %h expected %h", got, exp); end
    reset = 1'b1;
    #1;
    got = 64'({valid_o, first_o, next_o, last_o, underrun_o, taddr_o, idata_o, qdata_o, sig_ready_o});
    exp = 64'd0;
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL rst_mid_clear: got %h expected %h", got, exp); end
    tick();
    reset = 1'b0;
    tick();
    sig_valid_i = 1'b1; drive(8'h42);
    tick();
    sig_valid_i = 1'b0;
    tick();
    got = 64'({valid_o, first_o, last_o, underrun_o, taddr_o, idata_o});
    exp = 64'({1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h42});
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL rst_mid_restart: got %h expected %h", got, exp); end
  endtask

  task automatic test_random();
    int           sent = 0, gap = 0, rep = 0, vcnt = 0, fcnt = 0, lcnt = 0, cyc = 0;
    logic [W-1:0] q[$];
    logic [W-1:0] cur = '0;
    bit           acc;
    do_reset();
    en_i = 1'b1;
    gap = $urandom_range(0, 8);
    while ((sent < 12 || vcnt < 12 * TR) && cyc < 2000) begin
      acc = 1'b0;
      if (sent < 12 && gap == 0) begin
        sig_valid_i = 1'b1;
        drive(8'(8'h80 + sent));
        acc = sig_ready_o;
      end else begin
        sig_valid_i = 1'b0;
      end
      if (gap > 0) gap--;
      tick();
      cyc++;
      if (acc) begin
        q.push_back(sig_idata_i);
        sent++;
        gap = $urandom_range(0, 8);
      end
      if (valid_o === 1'b1) begin
        vcnt++;
        fcnt += int'(first_o);
        lcnt += int'(last_o);
        if (taddr_o == 2'd0) begin
          if (rep != 0) begin
            n_checks++;
            if (rep != TR) begin n_fail++; $display("FAIL rand_reps: got %0d expected %0d", rep, TR); end
          end
          if (q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL rand_extra_sample: got %h expected none", idata_o);
          end else begin
            cur = q.pop_front();
          end
          rep = 1;
        end else begin
          rep++;
        end
        got = 64'({idata_o, qdata_o, taddr_o});
        exp = 64'({cur, ~cur, 2'(rep - 1)});
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL rand_data vcnt=%0d: got %h expected %h", vcnt, got, exp); end
      end
    end
    sig_valid_i = 1'b0;
    got = 64'({32'(vcnt), 8'(fcnt), 8'(lcnt), 8'(q.size()), 8'(rep)});
    exp = 64'({32'(12 * TR), 8'd6, 8'd6, 8'd0, 8'(TR)});
    n_checks++;
    if (got !== exp || cyc >= 2000) begin n_fail++; $display("FAIL rand_totals cyc=%0d: got %h expected %h", cyc, got, exp); end
    tick();
    n_checks++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rand_idle: got %b expected 0", valid_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two();
    test_stream();
    test_en_drop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
